// File: rtl/nios_debug_cmd_dispatch.sv
// nios_debug_cmd_dispatch
// Brings JTAG update-DR / update-IR levels into the clk domain, captures the
// scan register on each update-DR edge and dispatches it as a one-cycle
// action or no-action strobe on the channel selected by the instruction.
// Only one command is held at a time; an update-DR edge that arrives while a
// command is held is dropped and flagged as an overrun.

module nios_debug_cmd_dispatch #(
   parameter  int SR_WIDTH    = 38,
   parameter  int IR_WIDTH    = 2,
   parameter  int SYNC_STAGES = 2,
   parameter  int ACT_BIT     = SR_WIDTH - 1,
   localparam int NUM_CH      = 2 ** IR_WIDTH
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                vs_udr,
   input  logic                vs_uir,
   input  logic [IR_WIDTH-1:0] ir_in,
   input  logic [SR_WIDTH-1:0] sr,
   input  logic [NUM_CH-1:0]   ch_ready,
   input  logic                overrun_clr,
   output logic [SR_WIDTH-1:0] jdo,
   output logic [NUM_CH-1:0]   take_action,
   output logic [NUM_CH-1:0]   take_no_action,
   output logic                busy,
   output logic                overrun,
   output logic [15:0]         cmd_count
);

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_t;

   state_t state, state_nxt;

   // Clock-domain crossing and edge detection
   logic [SYNC_STAGES-1:0] udr_sync;
   logic [SYNC_STAGES-1:0] uir_sync;
   logic [SYNC_STAGES-1:0] sync_vld;
   logic                   udr_prev;
   logic                   uir_prev;
   logic                   udr_armed;
   logic                   uir_armed;
   logic                   udr_out;
   logic                   uir_out;
   logic                   udr_rise;
   logic                   uir_rise;

   // Command state
   logic [SR_WIDTH-1:0] jdo_q, jdo_nxt;
   logic [IR_WIDTH-1:0] ir_q, ir_nxt;
   logic [NUM_CH-1:0]   act_q, act_nxt;
   logic [NUM_CH-1:0]   noact_q, noact_nxt;
   logic [NUM_CH-1:0]   ch_sel;
   logic                ch_rdy;
   logic                ovr_q, ovr_nxt;
   logic                drop;
   logic [15:0]         cnt_q, cnt_nxt;

   assign udr_out = udr_sync[SYNC_STAGES-1];
   assign uir_out = uir_sync[SYNC_STAGES-1];

   // Synchronise the JTAG levels and track whether each has been seen low.
   // The reset value of the synchroniser is not a real observation of the
   // input, so sync_vld marks when the chain has refilled from the pins; an
   // input must then be seen low before its first edge is accepted. This keeps
   // a level that is already high at reset release from dispatching a command.
   always_ff @(posedge clk) begin
      if (reset) begin
         udr_sync  <= '0;
         uir_sync  <= '0;
         sync_vld  <= '0;
         udr_prev  <= 1'b0;
         uir_prev  <= 1'b0;
         udr_armed <= 1'b0;
         uir_armed <= 1'b0;
      end else begin
         udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
         uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
         sync_vld  <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
         udr_prev  <= udr_out;
         uir_prev  <= uir_out;
         udr_armed <= udr_armed | (sync_vld[SYNC_STAGES-1] & ~udr_out);
         uir_armed <= uir_armed | (sync_vld[SYNC_STAGES-1] & ~uir_out);
      end
   end

   assign udr_rise = udr_out & ~udr_prev & udr_armed;
   assign uir_rise = uir_out & ~uir_prev & uir_armed;

   // Decode the held instruction into a channel select and its ready bit.
   always_comb begin
      ch_sel       = '0;
      ch_sel[ir_q] = 1'b1;
      ch_rdy       = ch_ready[ir_q];
   end

   // Next-state, capture, strobe and counter logic for the dispatcher.
   always_comb begin
      state_nxt = state;
      jdo_nxt   = jdo_q;
      ir_nxt    = ir_q;
      act_nxt   = '0;
      noact_nxt = '0;
      cnt_nxt   = cnt_q;
      drop      = 1'b0;

      case (state)
         IDLE: begin
            if (udr_rise) begin
               jdo_nxt   = sr;
               ir_nxt    = ir_in;
               state_nxt = PENDING;
            end
         end

         PENDING: begin
            // Any update-DR edge seen here is lost, including one that
            // coincides with the command leaving PENDING.
            drop = udr_rise;
            if (uir_rise) begin
               // An instruction update aborts the held command and takes
               // priority over a simultaneous ready.
               state_nxt = IDLE;
            end else if (ch_rdy) begin
               state_nxt = IDLE;
               cnt_nxt   = cnt_q + 16'd1;
               if (jdo_q[ACT_BIT]) begin
                  act_nxt = ch_sel;
               end else begin
                  noact_nxt = ch_sel;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      // A new drop wins over a simultaneous clear.
      if (drop) begin
         ovr_nxt = 1'b1;
      end else if (overrun_clr) begin
         ovr_nxt = 1'b0;
      end else begin
         ovr_nxt = ovr_q;
      end
   end

   // Register the dispatcher state and its outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         jdo_q   <= '0;
         ir_q    <= '0;
         act_q   <= '0;
         noact_q <= '0;
         ovr_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state   <= state_nxt;
         jdo_q   <= jdo_nxt;
         ir_q    <= ir_nxt;
         act_q   <= act_nxt;
         noact_q <= noact_nxt;
         ovr_q   <= ovr_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   assign jdo            = jdo_q;
   assign take_action    = act_q;
   assign take_no_action = noact_q;
   assign busy           = (state == PENDING);
   assign overrun        = ovr_q;
   assign cmd_count      = cnt_q;

endmodule

// File: tb/tb_nios_debug_cmd_dispatch.sv
// tb_nios_debug_cmd_dispatch
// Directed bench for the debug command dispatcher. Every command expected to
// strobe is pushed to a scoreboard when it is issued; a monitor pops and
// compares each strobe as it appears, and flags any strobe with nothing queued.

module tb_nios_debug_cmd_dispatch;

   typedef struct {
      logic [3:0]  act;
      logic [3:0]  noact;
      logic [37:0] jdo;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        vs_udr;
   logic        vs_uir;
   logic [1:0]  ir_in;
   logic [37:0] sr;
   logic [3:0]  ch_ready;
   logic        overrun_clr;
   logic [37:0] jdo;
   logic [3:0]  take_action;
   logic [3:0]  take_no_action;
   logic        busy;
   logic        overrun;
   logic [15:0] cmd_count;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [15:0] exp_cnt = 16'd0;
   exp_t        sb[$];
   exp_t        mon_e;

   localparam logic [37:0] SR_A = 38'h20_0000_1234;
   localparam logic [37:0] SR_B = 38'h00_0000_00AB;
   localparam logic [37:0] SR_C = 38'h20_0000_AAAA;
   localparam logic [37:0] SR_D = 38'h3F_FFFF_5555;
   localparam logic [37:0] SR_E = 38'h00_0000_0C0C;
   localparam logic [37:0] SR_F = 38'h20_0000_0D0D;
   localparam logic [37:0] SR_G = 38'h00_0000_0E0E;
   localparam logic [37:0] SR_H = 38'h20_0000_0F0F;
   localparam logic [37:0] SR_I = 38'h20_0000_0101;
   localparam logic [37:0] SR_J = 38'h20_0000_0202;

   nios_debug_cmd_dispatch #(
      .SR_WIDTH   (38),
      .IR_WIDTH   (2),
      .SYNC_STAGES(2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .vs_udr        (vs_udr),
      .vs_uir        (vs_uir),
      .ir_in         (ir_in),
      .sr            (sr),
      .ch_ready      (ch_ready),
      .overrun_clr   (overrun_clr),
      .jdo           (jdo),
      .take_action   (take_action),
      .take_no_action(take_no_action),
      .busy          (busy),
      .overrun       (overrun),
      .cmd_count     (cmd_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic cyc(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [3:0] act, input logic [3:0] noact, input logic [37:0] j);
      exp_cnt = exp_cnt + 16'd1;
      sb.push_back('{act: act, noact: noact, jdo: j, cnt: exp_cnt});
   endtask

   // Hold update-DR long enough to be captured, then low long enough to re-arm.
   task automatic send(input logic [37:0] s, input logic [1:0] ir);
      sr     = s;
      ir_in  = ir;
      vs_udr = 1'b1;
      cyc(3);
      vs_udr = 1'b0;
      cyc(3);
   endtask

   // Scoreboard monitor: every strobe must match the oldest queued command.
   always @(negedge clk) begin
      if ((take_action | take_no_action) != 4'b0000) begin
         n_vec++;
         assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL unexpected_strobe observed act=%b noact=%b expected none", take_action, take_no_action);
         end
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("sb_act", take_action, mon_e.act);
            chk("sb_noact", take_no_action, mon_e.noact);
            chk("sb_jdo", jdo, mon_e.jdo);
            chk("sb_count", cmd_count, mon_e.cnt);
         end
      end
   end

   initial begin
      reset       = 1'b1;
      vs_udr      = 1'b0;
      vs_uir      = 1'b0;
      ir_in       = 2'd0;
      sr          = '0;
      ch_ready    = 4'hF;
      overrun_clr = 1'b0;
      cyc(2);
      chk("rst_jdo", jdo, 0);
      chk("rst_act", take_action, 0);
      chk("rst_noact", take_no_action, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_count", cmd_count, 0);
      reset = 1'b0;
      cyc(4);

      // Basic action command and its latency from the first sampling edge.
      sr    = SR_A;
      ir_in = 2'd2;
      push_exp(4'b0100, 4'b0000, SR_A);
      vs_udr = 1'b1;
      cyc(3);
      chk("lat_early_act", take_action, 0);
      chk("lat_busy", busy, 1);
      cyc(1);
      chk("lat_act", take_action, 4'b0100);
      chk("lat_jdo", jdo, SR_A);
      chk("lat_count", cmd_count, 1);
      chk("lat_busy_done", busy, 0);
      cyc(1);
      chk("lat_act_one_cycle", take_action, 0);
      vs_udr = 1'b0;
      cyc(3);

      // No-action command held off by a not-ready channel.
      ch_ready = 4'b1101;
      send(SR_B, 2'd1);
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         chk("hold_busy", busy, 1);
         chk("hold_no_strobe", {take_action, take_no_action}, 0);
         chk("hold_jdo", jdo, SR_B);
      end
      push_exp(4'b0000, 4'b0010, SR_B);
      ch_ready = 4'hF;
      cyc(1);
      chk("ready_noact", take_no_action, 4'b0010);
      chk("ready_act", take_action, 0);
      chk("ready_busy", busy, 0);
      cyc(2);

      // Second update-DR while pending is dropped and flagged.
      ch_ready = 4'h0;
      send(SR_C, 2'd3);
      chk("ovr_busy", busy, 1);
      send(SR_D, 2'd0);
      chk("ovr_jdo_kept", jdo, SR_C);
      chk("ovr_set", overrun, 1);
      chk("ovr_busy2", busy, 1);
      push_exp(4'b1000, 4'b0000, SR_C);
      ch_ready = 4'hF;
      cyc(1);
      chk("ovr_act", take_action, 4'b1000);
      cyc(3);
      chk("ovr_sticky", overrun, 1);
      overrun_clr = 1'b1;
      cyc(1);
      overrun_clr = 1'b0;
      chk("ovr_cleared", overrun, 0);

      // Clear coinciding with a new drop leaves overrun set.
      ch_ready = 4'h0;
      send(SR_E, 2'd2);
      sr     = SR_D;
      vs_udr = 1'b1;
      cyc(2);
      overrun_clr = 1'b1;
      cyc(1);
      overrun_clr = 1'b0;
      chk("ovr_clr_vs_set", overrun, 1);
      vs_udr = 1'b0;
      cyc(3);
      chk("ovr_clr_jdo", jdo, SR_E);
      overrun_clr = 1'b1;
      cyc(1);
      overrun_clr = 1'b0;
      chk("ovr_cleared2", overrun, 0);

      // Update-IR aborts the pending command.
      chk("abort_busy_before", busy, 1);
      vs_uir = 1'b1;
      cyc(3);
      chk("abort_busy", busy, 0);
      vs_uir   = 1'b0;
      ch_ready = 4'hF;
      cyc(3);
      chk("abort_count", cmd_count, exp_cnt);
      chk("abort_jdo", jdo, SR_E);

      // Abort wins over a coincident ready.
      ch_ready = 4'h0;
      send(SR_F, 2'd1);
      chk("abort2_busy_before", busy, 1);
      vs_uir = 1'b1;
      cyc(2);
      ch_ready = 4'hF;
      cyc(1);
      chk("abort2_busy", busy, 0);
      chk("abort2_no_strobe", {take_action, take_no_action}, 0);
      vs_uir = 1'b0;
      cyc(3);
      chk("abort2_count", cmd_count, exp_cnt);

      // Update-DR on the same edge the command leaves PENDING is dropped.
      ch_ready = 4'h0;
      send(SR_G, 2'd0);
      push_exp(4'b0000, 4'b0001, SR_G);
      sr     = SR_H;
      ir_in  = 2'd3;
      vs_udr = 1'b1;
      cyc(2);
      ch_ready = 4'hF;
      cyc(1);
      chk("exit_drop_noact", take_no_action, 4'b0001);
      chk("exit_drop_ovr", overrun, 1);
      chk("exit_drop_jdo", jdo, SR_G);
      chk("exit_drop_busy", busy, 0);
      vs_udr = 1'b0;
      cyc(3);
      chk("exit_drop_idle", busy, 0);
      overrun_clr = 1'b1;
      cyc(1);
      overrun_clr = 1'b0;

      // Reset while pending discards the command and clears everything.
      ch_ready = 4'h0;
      send(SR_H, 2'd2);
      send(SR_I, 2'd1);
      chk("prerst_ovr", overrun, 1);
      chk("prerst_busy", busy, 1);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      exp_cnt = 16'd0;
      chk("midrst_jdo", jdo, 0);
      chk("midrst_act", take_action, 0);
      chk("midrst_noact", take_no_action, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_ovr", overrun, 0);
      chk("midrst_count", cmd_count, 0);
      ch_ready = 4'hF;
      cyc(4);
      chk("midrst_no_dispatch", busy, 0);

      // Update-DR already high at reset release must not dispatch.
      reset  = 1'b1;
      sr     = SR_I;
      ir_in  = 2'd1;
      vs_udr = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(8);
      chk("hi_rel_busy", busy, 0);
      chk("hi_rel_count", cmd_count, 0);
      chk("hi_rel_jdo", jdo, 0);
      vs_udr = 1'b0;
      cyc(4);
      push_exp(4'b0010, 4'b0000, SR_I);
      send(SR_I, 2'd1);
      chk("rearm_count", cmd_count, 1);
      chk("rearm_jdo", jdo, SR_I);

      // Counter wrap from 0xFFFF.
      force dut.cnt_q = 16'hFFFF;
      cyc(1);
      release dut.cnt_q;
      cyc(1);
      chk("wrap_preload", cmd_count, 16'hFFFF);
      exp_cnt = 16'hFFFF;
      push_exp(4'b0001, 4'b0000, SR_J);
      send(SR_J, 2'd0);
      chk("wrap_count", cmd_count, 16'h0000);

      cyc(2);
      chk("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/nios_debug_cmd_dispatch.md
NIOS_DEBUG_CMD_DISPATCH -- requirements
Module: nios_debug_cmd_dispatch

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- SR_WIDTH, 38, debug scan-register and jdo width; legal range 8..64.
- IR_WIDTH, 2, instruction width; legal range 1..4.
- NUM_CH, 2**IR_WIDTH, action channel count; derived, not overridable.
- SYNC_STAGES, 2, synchroniser depth for vs_udr and vs_uir; legal range 2..4.
- ACT_BIT, SR_WIDTH-1, jdo bit index selecting action (1) or no-action (0).

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, system clock; the only clock.
- reset, in, 1, synchronous, active-high reset.
- vs_udr, in, 1, update-DR level from the JTAG domain; asynchronous to clk.
- vs_uir, in, 1, update-IR level from the JTAG domain; asynchronous to clk.
- ir_in, in, IR_WIDTH, instruction; stable while vs_udr is high.
- sr, in, SR_WIDTH, scan register; stable while vs_udr is high.
- ch_ready, in, NUM_CH, per-channel consumer ready.
- overrun_clr, in, 1, clears overrun.
- jdo, out, SR_WIDTH, captured scan data.
- take_action, out, NUM_CH, one-hot single-cycle action strobe.
- take_no_action, out, NUM_CH, one-hot single-cycle no-action strobe.
- busy, out, 1, command pending.
- overrun, out, 1, sticky flag: command dropped.
- cmd_count, out, 16, count of dispatched commands.

Function
REQ-003 vs_udr and vs_uir SHALL each pass through SYNC_STAGES flops, followed by one edge-detect flop; a rising edge is sync_out=1 while prev=0.
REQ-004 The FSM SHALL have two states, IDLE and PENDING.
REQ-005 In IDLE, a udr rising edge SHALL, on the same clock edge, load jdo<=sr and ir_q<=ir_in, and move the FSM to PENDING.
REQ-006 In PENDING, the FSM SHALL return to IDLE on the first cycle where ch_ready[ir_q]=1.
REQ-007 On that same edge, the FSM SHALL register a one-cycle strobe on bit ir_q: take_action if jdo[ACT_BIT]=1, otherwise take_no_action.
REQ-008 Latency with ch_ready held at 1: a strobe SHALL be high exactly SYNC_STAGES+1 cycles after the first clk edge that samples vs_udr=1.
REQ-009 While ch_ready[ir_q]=0, the FSM SHALL stay in PENDING indefinitely, with no strobe and jdo held.
REQ-010 At most one bit across take_action and take_no_action combined SHALL be high in any cycle.
REQ-011 A udr rising edge while in PENDING SHALL be dropped: jdo and ir_q unchanged, overrun<=1.
REQ-012 A udr rising edge on the same cycle PENDING exits SHALL also be dropped and SHALL set overrun.
REQ-013 overrun SHALL stay set until overrun_clr=1.
REQ-014 If overrun_clr and a new overrun coincide, overrun SHALL remain 1.
REQ-015 A uir rising edge in PENDING SHALL abort the command: FSM to IDLE, no strobe, cmd_count unchanged, jdo retained.
REQ-016 If a uir edge and ch_ready[ir_q]=1 coincide in PENDING, the abort SHALL win.
REQ-017 busy SHALL equal (state==PENDING).
REQ-018 cmd_count SHALL increment by 1 per strobe and wrap 0xFFFF to 0x0000.
REQ-019 vs_udr held high SHALL produce exactly one edge; a new edge requires vs_udr to be seen low for at least one synchronised cycle.

Reset
REQ-020 While reset=1, all of the following SHALL be 0 at the next clk edge: synchroniser flops, edge flops, jdo, ir_q, take_action, take_no_action, busy, overrun, cmd_count; FSM SHALL be IDLE.
REQ-021 Reset asserted mid-PENDING SHALL discard the command with no strobe.
REQ-022 vs_udr high at reset release SHALL NOT create an edge until vs_udr is seen low, then high.

Verification
REQ-023 Defaults, ch_ready=4'hF, sr=38'h20_0000_1234, ir_in=2: pulse vs_udr ->
- jdo=38'h20_0000_1234;
- take_action=4'b0100 for one cycle, 3 cycles after first sampling;
- cmd_count=1.
REQ-024 sr bit 37=0, ir_in=1, ch_ready[1]=0 for 10 cycles, then 1 ->
- busy high throughout;
- take_no_action=4'b0010 on the cycle after ready rises;
- no other strobe.
REQ-025 Second vs_udr pulse while PENDING, with different sr ->
- jdo keeps first value;
- overrun=1 until overrun_clr;
- only one strobe occurs.
REQ-026 vs_uir pulse while PENDING ->
- busy drops;
- no strobe;
- cmd_count unchanged.
REQ-027 Preload cmd_count=0xFFFF via 65535 commands, then one more command -> cmd_count=0x0000.
REQ-028 reset asserted for one cycle while PENDING ->
- all outputs 0;
- a subsequent ch_ready rise produces no strobe.
